// File: rtl/board_drop_ctrl.sv
// Connect-4 board store: gravity drop resolution, row-wise clear sequencer and
// a single registered read path shared by three fixed-priority read ports.
module board_drop_ctrl #(
  parameter int unsigned ROWS   = 6,
  parameter int unsigned COLS   = 7,
  parameter int unsigned CELL_W = 2,
  parameter int unsigned RAW    = 3,
  parameter int unsigned CAW    = 3,
  parameter int unsigned MCW    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drop_valid,
  input  logic [CAW-1:0]         drop_col,
  input  logic [CELL_W-1:0]      drop_player,
  output logic                   drop_ready,
  output logic                   drop_done,
  output logic                   drop_err,
  output logic [RAW-1:0]         drop_row,
  input  logic                   clear_req,
  output logic                   clear_done,
  output logic                   busy,
  input  logic [2:0]             rd_req,
  input  logic [RAW-1:0]         rd_addr0,
  input  logic [RAW-1:0]         rd_addr1,
  input  logic [RAW-1:0]         rd_addr2,
  output logic [2:0]             rd_grant,
  output logic                   rd_valid,
  output logic [COLS*CELL_W-1:0] rd_data,
  output logic [MCW-1:0]         move_count,
  output logic                   board_full
);

  localparam int unsigned DW  = COLS * CELL_W;
  localparam int unsigned HW  = RAW + 1;
  localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, DROP, CLEAR} state_t;

  state_t state, state_nxt;

  logic [DW-1:0]     board  [ROWS];
  logic [HW-1:0]     height [COLS];
  logic [CAW-1:0]    col_q;
  logic [CELL_W-1:0] player_q;
  logic [RAW-1:0]    clr_row;

  logic              col_ok;
  logic [HW-1:0]     cur_h;
  logic              drop_bad;
  logic [DW-1:0]     row_wr;
  logic [2:0]        grant_nxt;
  logic [RAW-1:0]    sel_addr;

  assign drop_ready = (state == IDLE) & ~rst;
  assign busy       = (state != IDLE);
  assign board_full = (move_count == MCW'(ROWS * COLS));

  // Landing-row lookup and legality of the latched move
  always_comb begin
    col_ok   = (32'(col_q) < 32'(COLS));
    cur_h    = col_ok ? height[CIW'(col_q)] : '0;
    drop_bad = ~col_ok | (cur_h == HW'(ROWS)) | (player_q == '0);
    row_wr   = board[RIW'(cur_h)];
    for (int c = 0; c < int'(COLS); c++) begin
      if (32'(c) == 32'(col_q)) row_wr[c*CELL_W +: CELL_W] = player_q;
    end
  end

  // Read arbitration: check > put > display
  always_comb begin
    grant_nxt = 3'b000;
    sel_addr  = rd_addr0;
    if (rd_req[2]) begin
      grant_nxt = 3'b100;
      sel_addr  = rd_addr2;
    end else if (rd_req[1]) begin
      grant_nxt = 3'b010;
      sel_addr  = rd_addr1;
    end else if (rd_req[0]) begin
      grant_nxt = 3'b001;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_req)       state_nxt = CLEAR;
        else if (drop_valid) state_nxt = DROP;
      end
      DROP:  state_nxt = IDLE;
      CLEAR: if (clr_row == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(ROWS); r++) board[r] <= '0;
      for (int c = 0; c < int'(COLS); c++) height[c] <= '0;
      col_q      <= '0;
      player_q   <= '0;
      clr_row    <= '0;
      drop_done  <= 1'b0;
      drop_err   <= 1'b0;
      drop_row   <= '0;
      clear_done <= 1'b0;
      move_count <= '0;
      rd_valid   <= 1'b0;
      rd_grant   <= '0;
      rd_data    <= '0;
    end else begin
      drop_done  <= 1'b0;
      drop_err   <= 1'b0;
      clear_done <= 1'b0;

      case (state)
        IDLE: begin
          if (clear_req) begin
            for (int c = 0; c < int'(COLS); c++) height[c] <= '0;
            move_count <= '0;
            clr_row    <= RAW'(ROWS - 1);
          end else if (drop_valid) begin
            col_q    <= drop_col;
            player_q <= drop_player;
          end
        end
        DROP: begin
          drop_done <= 1'b1;
          if (drop_bad) begin
            drop_err <= 1'b1;
            drop_row <= '0;
          end else begin
            board[RIW'(cur_h)]  <= row_wr;
            height[CIW'(col_q)] <= cur_h + HW'(1);
            drop_row            <= RAW'(cur_h);
            move_count          <= move_count + MCW'(1);
          end
        end
        CLEAR: begin
          board[RIW'(clr_row)] <= '0;
          if (clr_row == '0) clear_done <= 1'b1;
          else               clr_row    <= clr_row - RAW'(1);
        end
        default: ;
      endcase

      // Reads see the board as it was before this edge's write
      rd_valid <= |rd_req;
      rd_grant <= grant_nxt;
      if (|rd_req) rd_data <= (32'(sel_addr) < 32'(ROWS)) ? board[RIW'(sel_addr)] : '0;
    end
  end

endmodule
